rng_roll_ctrl: RTL and testbench
================================

# rng_roll_ctrl

Sequencer for the DE2 random-number display. On a start press it runs a timed "rolling dice" animation, then holds a final value. Each animation step draws a fresh sample from a free-running 16-bit LFSR and drives two BCD digit codes into two downstream BCD-to-7-segment decoders (tens and units HEX digits). Between rolls it blanks the display or holds the result.

## Interface
Parameters:
- MAX_VAL, 99, upper bound of the drawn value. Legal range is 1..99; range drawn is 0..MAX_VAL.
- TICK_DIV, 2500000, clock cycles per animation step (50 ms at 50 MHz). Must be at least 2.
- ROLL_TICKS, 40, animation steps per roll. Must be at least 1.
- LFSR_SEED, 16'hACE1, LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  roll request, level input (already debounced). Only the rising edge acts.
- tens  out  4  BCD tens digit to decoder; 4'hF = blank.
- units  out  4  BCD units digit to decoder; 4'hF = blank.
- value  out  7  binary value currently displayed.
- busy  out  1  high while rolling.
- done  out  1  one-cycle pulse when the final value is latched.

## Operation
- **Clock and reset:** one clock (clk); reset (rst) is synchronous and active-high.
- **Reset values:** state=IDLE, tens=units=4'hF, value=0, busy=0, done=0, tick_cnt=0, roll_cnt=0, lfsr=LFSR_SEED, start_q=1.
  - start_q resets to 1 so that a start held high through reset release does not trigger a roll.
- **LFSR:** 16-bit Galois, shift right. If lfsr[0]=1, then after the shift XOR with 16'hB400.
  - Advances every cycle in every state, including the cycle rst is deasserted.
  - Never reaches zero.
- **Sample:** s = lfsr[6:0] % (MAX_VAL+1), combinational.
- **BCD:** tens = v/10, units = v%10, computed from the registered value.
- **Start edge:** start_edge = start & ~start_q; start_q <= start every cycle.
- **States:**
  - IDLE: tens/units=4'hF, busy=0. On start_edge: go to ROLL, load value<=s, clear tick_cnt and roll_cnt.
  - ROLL: busy=1. tick_cnt increments each cycle.
    - At tick_cnt==TICK_DIV-1: tick_cnt<=0 and value<=s.
    - If roll_cnt==ROLL_TICKS-1 on that tick: go to HOLD and pulse done. Otherwise roll_cnt increments.
    - start_edge in ROLL is ignored.
  - HOLD: busy=0; display holds value. start_edge behaves exactly as in IDLE, restarting a roll. There is no return to IDLE except via rst.
- **Step count:** a roll shows 1 + ROLL_TICKS value updates (the entry load plus one per tick). The final displayed value is the last tick's sample.
- **Reset mid-roll:** takes effect on the next edge. All registers return to their reset values and no done pulse is issued.
- **Simultaneous rst and start_edge:** rst wins.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let edge E be the clock edge at which start=1 and start_q=0 are sampled.
  - E+1: busy=1; value and digits show the first sample.
  - k-th tick update is visible at E + k·TICK_DIV + 1, for k=1..ROLL_TICKS.
  - done=1 and busy=0 at cycle E + ROLL_TICKS·TICK_DIV + 1. done stays high for exactly one cycle.
- Going from blank to digits occurs one cycle after E.
- A start edge in HOLD, sampled at edge H, gives busy=1 at H+1; the done→busy gap has no minimum.
- A start pulse of one cycle is sufficient. A held start produces only one roll.

## Test plan
1. **Reset:** assert rst with start=1, then release while start is held high. Required: tens=units=4'hF, value=0, busy=0, done=0, and no roll starts until start drops and rises again.
2. **Roll timing** (TICK_DIV=4, ROLL_TICKS=3): start rises, edge E. Required:
   - busy=1 from E+1 through E+12.
   - value updates at E+1, E+5, E+9, E+13.
   - done=1 only at E+13, with busy=0 at E+13.
3. **Value checks:** at every update, value equals s from a bench LFSR model (seed 16'hACE1, poly 16'hB400), value ≤ MAX_VAL, and {tens,units} = BCD(value), e.g. 57 → 4'h5, 4'h7. Repeat with MAX_VAL=9 and require tens=0 always.
4. **Restart/ignore:** pulse start again mid-ROLL. Required: no timing change and done at the original cycle. Then pulse start in HOLD. Required: new roll, with busy at the next cycle.
5. **Reset mid-roll:** assert rst at E+6 for one cycle. Required: at E+7 outputs are blank/0/0/0 and no done occurs. The LFSR restarts from 16'hACE1, matching the model.
6. **Long run:** 1000 rolls with random start spacing. Required: LFSR never reaches 0, every done pulse is 1 cycle, and there is exactly one done per accepted start.

Source files
------------

// File: rtl/rng_roll_ctrl.sv
// rng_roll_ctrl: timed dice-roll sequencer drawing LFSR samples onto two BCD digits
module rng_roll_ctrl #(
    parameter int          MAX_VAL    = 99,
    parameter int          TICK_DIV   = 2500000,
    parameter int          ROLL_TICKS = 40,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [6:0] value,
    output logic       busy,
    output logic       done
);
    localparam int         TW  = $clog2(TICK_DIV + 1);
    localparam int         RW  = $clog2(ROLL_TICKS + 1);
    localparam logic [6:0] MOD = 7'(MAX_VAL + 1);

    typedef enum logic [1:0] {IDLE, ROLL, HOLD} state_t;

    state_t          state, state_n;
    logic [15:0]     lfsr;
    logic [TW-1:0]   tick_cnt, tick_n;
    logic [RW-1:0]   roll_cnt, roll_n;
    logic [6:0]      value_n, s;
    logic            start_q, start_edge, tick, done_n;

    assign s          = lfsr[6:0] % MOD;
    assign start_edge = start & ~start_q;
    assign tick       = tick_cnt == TW'(TICK_DIV - 1);

    always_comb begin
        state_n = state;
        value_n = value;
        tick_n  = tick_cnt;
        roll_n  = roll_cnt;
        done_n  = 1'b0;
        if (state == ROLL) begin
            tick_n = tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                value_n = s;
                roll_n  = roll_cnt + 1'b1;
                if (roll_cnt == RW'(ROLL_TICKS - 1)) begin
                    state_n = HOLD;
                    done_n  = 1'b1;
                end
            end
        end else if (start_edge) begin
            state_n = ROLL;
            value_n = s;
            tick_n  = '0;
            roll_n  = '0;
        end
    end

    // start_q resets high so a start held through reset release is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            value    <= '0;
            done     <= 1'b0;
            tick_cnt <= '0;
            roll_cnt <= '0;
            lfsr     <= LFSR_SEED;
            start_q  <= 1'b1;
        end else begin
            state    <= state_n;
            value    <= value_n;
            done     <= done_n;
            tick_cnt <= tick_n;
            roll_cnt <= roll_n;
            lfsr     <= lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
            start_q  <= start;
        end
    end

    assign busy  = state == ROLL;
    assign tens  = state == IDLE ? 4'hF : 4'(value / 7'd10);
    assign units = state == IDLE ? 4'hF : 4'(value % 7'd10);
endmodule

// File: tb/tb_rng_roll_ctrl.sv
// tb_rng_roll_ctrl: randomized roll sequencing checked against a cycle-indexed reference model
module tb_rng_roll_ctrl;
    localparam int TD = 4;
    localparam int RT = 3;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b1;
    logic [3:0] t99, u99, t9, u9;
    logic [6:0] v99, v9;
    logic       b99, b9, dn99, dn9;

    rng_roll_ctrl #(.MAX_VAL(99), .TICK_DIV(TD), .ROLL_TICKS(RT), .LFSR_SEED(16'hACE1)) d99 (
        .clk(clk), .rst(rst), .start(start), .tens(t99), .units(u99),
        .value(v99), .busy(b99), .done(dn99));
    rng_roll_ctrl #(.MAX_VAL(9), .TICK_DIV(TD), .ROLL_TICKS(RT), .LFSR_SEED(16'hACE1)) d9 (
        .clk(clk), .rst(rst), .start(start), .tens(t9), .units(u9),
        .value(v9), .busy(b9), .done(dn9));

    always #5 clk = ~clk;

    int          vectors = 0, miscompares = 0;
    int          cyc = 0, e_cyc = 0, accepted = 0, dones = 0;
    int          mode = 0;
    logic [15:0] m_lfsr;
    logic        m_sq, m_done;
    logic [6:0]  m99, m9;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic pulse(input int n);
        start = 1'b1;
        repeat (n) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // mode 0 = blank, 1 = rolling, 2 = holding; roll timing derived from cycles since the start edge
    initial forever begin
        @(posedge clk);
        begin
            int d;
            logic [6:0] s99, s9;
            s99 = 7'(int'(m_lfsr[6:0]) % 100);
            s9  = 7'(int'(m_lfsr[6:0]) % 10);
            cyc++;
            if (rst) begin
                m_lfsr = 16'hACE1;
                mode   = 0;
                m99    = 0;
                m9     = 0;
                m_done = 1'b0;
                m_sq   = 1'b1;
            end else begin
                m_done = 1'b0;
                if (mode != 1 && start && !m_sq) begin
                    mode  = 1;
                    e_cyc = cyc;
                    m99   = s99;
                    m9    = s9;
                    accepted++;
                end else if (mode == 1) begin
                    d = cyc - e_cyc;
                    if (d % TD == 0) begin
                        m99 = s99;
                        m9  = s9;
                    end
                    if (d == RT * TD) begin
                        mode   = 2;
                        m_done = 1'b1;
                    end
                end
                m_lfsr = m_lfsr[0] ? (m_lfsr >> 1) ^ 16'hB400 : m_lfsr >> 1;
                m_sq   = start;
            end
            chk_en = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy", int'(b99), int'(mode == 1));
            chk("busy9", int'(b9), int'(mode == 1));
            chk("done", int'(dn99), int'(m_done));
            chk("done9", int'(dn9), int'(m_done));
            chk("value", int'(v99), int'(m99));
            chk("tens", int'(t99), mode == 0 ? 15 : int'(m99) / 10);
            chk("units", int'(u99), mode == 0 ? 15 : int'(m99) % 10);
            chk("value9", int'(v9), int'(m9));
            chk("tens9", int'(t9), mode == 0 ? 15 : 0);
            chk("units9", int'(u9), mode == 0 ? 15 : int'(m9));
            chk("value_max", int'(v99 <= 7'd99), 1);
            chk("lfsr", int'(d99.lfsr), int'(m_lfsr));
            chk("lfsr_nonzero", int'(d99.lfsr != 16'h0), 1);
            if (dn99) dones++;
        end
    end

    initial begin
        int base_acc, base_done;
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_start_no_roll", int'(b99), 0);
        chk("held_start_blank", int'(t99), 15);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        pulse(1);
        repeat (10) @(negedge clk);
        pulse(1);
        repeat (16) @(negedge clk);

        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("pin_first_value", int'(v99), 12);
        chk("pin_first_tens", int'(t99), 1);
        chk("pin_first_units", int'(u99), 2);
        chk("pin_first_value9", int'(v9), 2);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pin_tick1_value", int'(v99), 39);
        chk("pin_tick1_value9", int'(v9), 9);
        @(negedge clk);
        base_done = dones;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(b99), 0);
        chk("midrst_value", int'(v99), 0);
        chk("midrst_units", int'(u99), 15);
        repeat (20) @(negedge clk);
        chk("midrst_no_done", dones - base_done, 0);

        base_acc  = accepted;
        base_done = dones;
        while (accepted - base_acc < 1000 && cyc < 90000) begin
            start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 18)) @(negedge clk);
        end
        repeat (16) @(negedge clk);
        chk("roll_budget", int'(accepted - base_acc >= 1000), 1);
        chk("done_per_start", dones - base_done, accepted - base_acc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
